// File: rtl/sha1_job_arbiter_if.sv
// Host-side job interface for sha1_job_arbiter: request (addr/size) and digest response channels.
// The arbiter connects through the slave modport; the requester side uses master.
interface sha1_job_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_size;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [159:0]          rsp_hash;
    logic                  rsp_error;

    modport master (
        output req_valid, req_addr, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_hash, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_hash, rsp_error
    );
endinterface

// File: rtl/sha1_job_arbiter.sv
// Round-robin sharing of one SHA-1 core among NUM_REQ job ports: clear, start, wait, return digest.
// Define SHA1_ARB_TIMEOUT_EN to add a BUSY watchdog that aborts hung jobs with rsp_error.
module sha1_job_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 65536
) (
    input  logic              clk_i,
    input  logic              reset_i,
    sha1_job_arbiter_if.slave job,
    output logic              core_nreset_o,
    output logic              core_start_o,
    output logic [31:0]       core_addr_o,
    output logic [31:0]       core_size_o,
    input  logic [159:0]      core_hash_i,
    input  logic              core_done_i
);
    localparam int unsigned     IdxW    = $clog2(NUM_REQ);
    localparam int unsigned     CntW    = $clog2(CLR_CYCLES + 1);
    localparam logic [CntW-1:0] LastClr = CntW'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StClear, StStart, StBusy, StResp} state_e;

    state_e             state_q;
    logic [IdxW-1:0]    rr_ptr_q;
    logic [IdxW-1:0]    grant_q;
    logic [CntW-1:0]    clr_cnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [159:0]       rsp_hash_q;
    logic               core_nreset_q;
    logic               core_start_q;
    logic [31:0]        core_addr_q;
    logic [31:0]        core_size_q;
`ifdef SHA1_ARB_TIMEOUT_EN
    logic               rsp_error_q;
    logic [31:0]        wdog_q;
`else
    logic               unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    logic               grant_vld;
    logic [IdxW-1:0]    grant_idx;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_size;

    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IdxW'(s);
    endfunction

    // First pending requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && job.req_valid[wrap_add(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_size = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdxW'(i) == grant_idx) begin
                sel_addr = job.req_addr[32*i +: 32];
                sel_size = job.req_size[32*i +: 32];
            end
        end
    end

    always_comb begin
        job.req_ready = '0;
        if (!reset_i && state_q == StIdle && grant_vld) job.req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            clr_cnt_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_hash_q    <= '0;
            core_nreset_q <= 1'b0;
            core_start_q  <= 1'b0;
            core_addr_q   <= '0;
            core_size_q   <= '0;
`ifdef SHA1_ARB_TIMEOUT_EN
            rsp_error_q   <= 1'b0;
            wdog_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        grant_q       <= grant_idx;
                        core_addr_q   <= sel_addr;
                        core_size_q   <= sel_size;
                        core_nreset_q <= 1'b0;
                        clr_cnt_q     <= '0;
                        state_q       <= StClear;
                    end
                end
                StClear: begin
                    if (clr_cnt_q == LastClr) begin
                        core_nreset_q <= 1'b1;
                        core_start_q  <= 1'b1;
                        state_q       <= StStart;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                StStart: begin
                    core_start_q <= 1'b0;
`ifdef SHA1_ARB_TIMEOUT_EN
                    wdog_q       <= '0;
`endif
                    state_q      <= StBusy;
                end
                StBusy: begin
                    if (core_done_i) begin
                        rsp_hash_q  <= core_hash_i;
                        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
`ifdef SHA1_ARB_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
`endif
                        state_q     <= StResp;
                    end
`ifdef SHA1_ARB_TIMEOUT_EN
                    else if (wdog_q == 32'(TIMEOUT - 1)) begin
                        rsp_hash_q  <= '0;
                        rsp_error_q <= 1'b1;
                        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                        state_q     <= StResp;
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
                    end
`endif
                end
                StResp: begin
                    if (job.rsp_ready[grant_q]) begin
                        rsp_valid_q <= '0;
                        rr_ptr_q    <= wrap_add(grant_q, 1);
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign job.rsp_valid = rsp_valid_q;
    assign job.rsp_hash  = rsp_hash_q;
`ifdef SHA1_ARB_TIMEOUT_EN
    assign job.rsp_error = rsp_error_q;
`else
    assign job.rsp_error = 1'b0;
`endif
    assign core_nreset_o = core_nreset_q;
    assign core_start_o  = core_start_q;
    assign core_addr_o   = core_addr_q;
    assign core_size_o   = core_size_q;
endmodule

// File: tb/tb_sha1_job_arbiter.sv
// Bench for sha1_job_arbiter with a behavioural SHA-1 core stand-in and a response scoreboard.
// Define SHA1_ARB_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_sha1_job_arbiter;
    localparam int unsigned NR  = 4;
    localparam int unsigned CLR = 2;
    localparam int unsigned TO  = 100;
    localparam int unsigned LAT = 5;
    localparam logic [159:0] ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

    typedef struct {
        int           idx;
        logic [159:0] hash;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         core_nreset, core_start;
    logic [31:0]  core_addr, core_size;
    logic [159:0] core_hash = '0;
    logic         core_done = 1'b0;
    logic         running = 1'b0;
    logic         hang = 1'b0;
    int           busy_cnt = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         sb[$];

    always #5 clk = ~clk;

    sha1_job_arbiter_if #(.NUM_REQ(NR)) job ();

    sha1_job_arbiter #(.NUM_REQ(NR), .CLR_CYCLES(CLR), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .job          (job.slave),
        .core_nreset_o(core_nreset),
        .core_start_o (core_start),
        .core_addr_o  (core_addr),
        .core_size_o  (core_size),
        .core_hash_i  (core_hash),
        .core_done_i  (core_done)
    );

    // Known digests for the two reference messages, otherwise a tag derived from addr/size.
    function automatic logic [159:0] model_hash(input logic [31:0] a, input logic [31:0] s);
        if (s == 32'd0) return EMPTY;
        if (a == 32'h100 && s == 32'd3) return ABC;
        return {a, s, a ^ s, ~a, ~s};
    endfunction

    // Core stand-in: done rises LAT cycles after start and stays high until the core is reset.
    always @(posedge clk) begin
        if (!core_nreset) begin
            core_done <= 1'b0;
            running   <= 1'b0;
            busy_cnt  <= 0;
        end else if (core_start) begin
            running   <= 1'b1;
            busy_cnt  <= 0;
            core_hash <= model_hash(core_addr, core_size);
        end else if (running && !core_done && !hang) begin
            if (busy_cnt == LAT) core_done <= 1'b1;
            else busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] s);
        job.req_addr[32*i +: 32] = a;
        job.req_size[32*i +: 32] = s;
    endtask

    task automatic wait_rsp(output bit timed_out, output int readies);
        timed_out = 1'b1;
        readies   = 0;
        for (int c = 0; c < 400; c++) begin
            if (|job.rsp_valid) begin
                timed_out = 1'b0;
                return;
            end
            if (|job.req_ready) readies++;
            tick();
        end
    endtask

    task automatic wait_start(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (core_start) begin
                timed_out = 1'b0;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        job.req_valid = '0;
        job.rsp_ready = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({job.req_ready, job.rsp_valid, job.rsp_error, core_nreset, core_start} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b err=%b nrst=%b start=%b, want all 0",
                     job.req_ready, job.rsp_valid, job.rsp_error, core_nreset, core_start);
        end
        n_checks++;
        if (job.rsp_hash !== '0) begin
            n_fail++;
            $display("FAIL reset_hash: got %h want 0", job.rsp_hash);
        end
        n_checks++;
        if ({core_addr, core_size} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_core_bus: got addr=%h size=%h want 0", core_addr, core_size);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   lat, low, prev;
        bit   to;
        set_slot(0, 32'h100, 32'd3);
        job.req_valid = 4'b0001;
        #1;
        n_checks++;
        if (job.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0001", job.req_ready);
        end
        sb.push_back('{0, model_hash(32'h100, 32'd3), 1'b0});
        tick();
        job.req_valid = '0;
        lat = 0;
        low = 0;
        for (int c = 1; c <= 20; c++) begin
            if (core_start) begin
                lat = c;
                break;
            end
            if (!core_nreset) low++;
            tick();
        end
        n_checks++;
        if (lat != CLR + 1 || low != CLR || core_nreset !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start_latency: got lat=%0d low=%0d nrst=%b want lat=%0d low=%0d nrst=1",
                     lat, low, core_nreset, CLR + 1, CLR);
        end
        n_checks++;
        if (core_addr !== 32'h100 || core_size !== 32'd3) begin
            n_fail++;
            $display("FAIL single_core_bus: got addr=%h size=%h want 100/3", core_addr, core_size);
        end
        tick();
        n_checks++;
        if (core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start_pulse: got start=%b want 0", core_start);
        end
        prev = 0;
        to = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (|job.rsp_valid) begin
                to = 1'b0;
                break;
            end
            prev = int'(core_done);
            tick();
        end
        n_checks++;
        if (to || prev != 1) begin
            n_fail++;
            $display("FAIL single_done_latency: got timeout=%b prev_done=%0d want 0/1", to, prev);
        end
        e = sb.pop_front();
        n_checks++;
        if (job.rsp_valid !== (NR'(1) << e.idx) || job.rsp_hash !== e.hash ||
            job.rsp_error !== e.err) begin
            n_fail++;
            $display("FAIL single_rsp: got vld=%b hash=%h err=%b want vld=%b hash=%h err=%b",
                     job.rsp_valid, job.rsp_hash, job.rsp_error, NR'(1) << e.idx, e.hash, e.err);
        end
        job.rsp_ready = 4'b0001;
        tick();
        job.rsp_ready = '0;
        n_checks++;
        if (job.rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL single_rsp_clear: got %b want 0000", job.rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   to;
        int   rd;
        int   order[5] = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_slot(i, 32'h1000 + 32'h40 * i, 32'd17 + i);
        foreach (order[k])
            sb.push_back('{order[k], model_hash(32'h1000 + 32'h40 * order[k], 32'd17 + order[k]), 1'b0});
        job.req_valid = 4'b1111;
        job.rsp_ready = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) begin
            wait_rsp(to, rd);
            e = sb.pop_front();
            n_checks++;
            if (to || rd != 1) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got timeout=%b grants=%0d want 0/1", j, to, rd);
            end
            n_checks++;
            if (job.rsp_valid !== (NR'(1) << e.idx) || job.rsp_hash !== e.hash) begin
                n_fail++;
                $display("FAIL rr_rsp_%0d: got vld=%b hash=%h want vld=%b hash=%h",
                         j, job.rsp_valid, job.rsp_hash, NR'(1) << e.idx, e.hash);
            end
            tick();
        end
        job.req_valid = '0;
        job.rsp_ready = '0;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t         e;
        bit           to;
        int           rd, bad;
        logic [159:0] held;
        set_slot(2, 32'h2222_0000, 32'd64);
        job.req_valid = 4'b0100;
        #1;
        sb.push_back('{2, model_hash(32'h2222_0000, 32'd64), 1'b0});
        wait_rsp(to, rd);
        e = sb.pop_front();
        n_checks++;
        if (to || job.rsp_valid !== (NR'(1) << e.idx) || job.rsp_hash !== e.hash) begin
            n_fail++;
            $display("FAIL bp_rsp: got to=%b vld=%b hash=%h want vld=%b hash=%h",
                     to, job.rsp_valid, job.rsp_hash, NR'(1) << e.idx, e.hash);
        end
        set_slot(1, 32'h1111_0000, 32'd5);
        job.req_valid = 4'b0010;
        sb.push_back('{1, model_hash(32'h1111_0000, 32'd5), 1'b0});
        held = job.rsp_hash;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (job.rsp_valid !== 4'b0100 || job.rsp_hash !== held || job.req_ready !== '0 ||
                core_start !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d disturbed cycles want 0", bad);
        end
        job.rsp_ready = 4'b1011;
        tick();
        n_checks++;
        if (job.rsp_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_foreign_ready: got vld=%b want 0100", job.rsp_valid);
        end
        job.rsp_ready = 4'b0100;
        tick();
        job.rsp_ready = '0;
        #1;
        n_checks++;
        if (job.rsp_valid !== '0 || job.req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_next_grant: got vld=%b rdy=%b want 0000/0010",
                     job.rsp_valid, job.req_ready);
        end
        wait_rsp(to, rd);
        job.req_valid = '0;
        e = sb.pop_front();
        n_checks++;
        if (to || job.rsp_valid !== (NR'(1) << e.idx) || job.rsp_hash !== e.hash) begin
            n_fail++;
            $display("FAIL bp_second_rsp: got to=%b vld=%b hash=%h want vld=%b hash=%h",
                     to, job.rsp_valid, job.rsp_hash, NR'(1) << e.idx, e.hash);
        end
        job.rsp_ready = 4'b0010;
        tick();
        job.rsp_ready = '0;
    endtask

    task automatic test_reset_mid_busy();
        bit to;
        int seen;
        set_slot(3, 32'h3333_0000, 32'd9);
        job.req_valid = 4'b1000;
        #1;
        tick();
        job.req_valid = '0;
        wait_start(to);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (to || {job.req_ready, job.rsp_valid, job.rsp_error, core_nreset, core_start} !== '0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got to=%b rdy=%b vld=%b err=%b nrst=%b start=%b want 0",
                     to, job.req_ready, job.rsp_valid, job.rsp_error, core_nreset, core_start);
        end
        n_checks++;
        if (job.rsp_hash !== '0 || core_addr !== '0 || core_size !== '0) begin
            n_fail++;
            $display("FAIL midreset_regs: got hash=%h addr=%h size=%h want 0",
                     job.rsp_hash, core_addr, core_size);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (|job.rsp_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_dropped: got %0d rsp cycles want 0", seen);
        end
        job.req_valid = 4'b1111;
        #1;
        n_checks++;
        if (job.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_rr_ptr: got rdy=%b want 0001", job.req_ready);
        end
        job.req_valid = '0;
        tick();
    endtask

    task automatic test_empty();
        exp_t e;
        bit   to;
        int   rd;
        set_slot(0, 32'h200, 32'd0);
        job.req_valid = 4'b0001;
        #1;
        sb.push_back('{0, EMPTY, 1'b0});
        tick();
        job.req_valid = '0;
        wait_start(to);
        n_checks++;
        if (to || core_size !== 32'd0 || core_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL empty_core_bus: got to=%b addr=%h size=%h want 200/0",
                     to, core_addr, core_size);
        end
        wait_rsp(to, rd);
        e = sb.pop_front();
        n_checks++;
        if (to || job.rsp_valid !== (NR'(1) << e.idx) || job.rsp_hash !== e.hash) begin
            n_fail++;
            $display("FAIL empty_rsp: got to=%b vld=%b hash=%h want vld=%b hash=%h",
                     to, job.rsp_valid, job.rsp_hash, NR'(1) << e.idx, e.hash);
        end
        job.rsp_ready = 4'b0001;
        tick();
        job.rsp_ready = '0;
    endtask

`ifdef SHA1_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        bit   to;
        int   rd, n;
        hang = 1'b1;
        set_slot(1, 32'h4444, 32'd12);
        job.req_valid = 4'b0010;
        #1;
        sb.push_back('{1, 160'd0, 1'b1});
        tick();
        job.req_valid = '0;
        wait_start(to);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            n++;
            if (|job.rsp_valid) break;
        end
        e = sb.pop_front();
        n_checks++;
        if (to || n != TO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got to=%b cycles=%0d want %0d", to, n, TO + 1);
        end
        n_checks++;
        if (job.rsp_valid !== (NR'(1) << e.idx) || job.rsp_hash !== e.hash ||
            job.rsp_error !== e.err) begin
            n_fail++;
            $display("FAIL timeout_rsp: got vld=%b hash=%h err=%b want vld=%b hash=%h err=%b",
                     job.rsp_valid, job.rsp_hash, job.rsp_error, NR'(1) << e.idx, e.hash, e.err);
        end
        hang = 1'b0;
        job.rsp_ready = 4'b0010;
        tick();
        job.rsp_ready = '0;
        set_slot(2, 32'h55, 32'd7);
        job.req_valid = 4'b0100;
        #1;
        sb.push_back('{2, model_hash(32'h55, 32'd7), 1'b0});
        tick();
        job.req_valid = '0;
        wait_rsp(to, rd);
        e = sb.pop_front();
        n_checks++;
        if (to || job.rsp_valid !== (NR'(1) << e.idx) || job.rsp_hash !== e.hash ||
            job.rsp_error !== e.err) begin
            n_fail++;
            $display("FAIL timeout_recover: got to=%b vld=%b hash=%h err=%b want vld=%b hash=%h err=0",
                     to, job.rsp_valid, job.rsp_hash, job.rsp_error, NR'(1) << e.idx, e.hash);
        end
        job.rsp_ready = 4'b0100;
        tick();
        job.rsp_ready = '0;
    endtask
`endif

    initial begin
        job.req_valid = '0;
        job.req_addr  = '0;
        job.req_size  = '0;
        job.rsp_ready = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_busy();
        test_empty();
`ifdef SHA1_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit expired");
    end
endmodule
